// File: rtl/cpu_sequencer.sv
// Control sequencer for the Simple RISC Machine: fetch, PC advance, decode, execute.
// Latency: 4-cycle fetch/decode; 5 to 10 cycles per instruction including fetch.
// Backpressure: none; synchronous memory with 1-cycle read latency is assumed.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   opcode, op, cond    instruction fields from the decoder (stable from UPC onwards)
//   Z, N, V             status flags, sampled only in the branch state
//   nsel .. halted      datapath, PC, IR and memory strobes (registered, except the
//                       branch PC load, which also depends on cond and the flags)
module cpu_sequencer #(
    parameter logic [1:0] MNONE  = 2'b00,
    parameter logic [1:0] MREAD  = 2'b01,
    parameter logic [1:0] MWRITE = 2'b10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    input  logic [2:0] cond,
    input  logic       Z,
    input  logic       N,
    input  logic       V,
    output logic [2:0] nsel,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic [1:0] vsel,
    output logic       write,
    output logic       load_ir,
    output logic       load_pc,
    output logic       reset_pc,
    output logic [1:0] pc_sel,
    output logic       addr_sel,
    output logic       load_addr,
    output logic [1:0] mem_cmd,
    output logic       halted
);

    typedef enum logic [4:0] {
        S_RST, S_IF1, S_IF2, S_UPC, S_DEC,
        S_MOVI,
        S_GA, S_GB, S_EX, S_EXA, S_CMP, S_WR,
        S_ADR, S_LA, S_MR, S_WM,
        S_GD, S_MB, S_MW,
        S_BR,
        S_BGD, S_BMB, S_BP,
        S_HLT
    } state_t;

    typedef struct packed {
        logic [2:0] nsel;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] vsel;
        logic       write;
        logic       load_ir;
        logic       load_pc;
        logic       reset_pc;
        logic [1:0] pc_sel;
        logic       addr_sel;
        logic       load_addr;
        logic [1:0] mem_cmd;
        logic       halted;
    } ctrl_t;

    state_t state;
    state_t nxt;
    ctrl_t  ctrl;
    logic   taken;

    // Strobes for a given state. Evaluated on the next state so that the
    // registered outputs line up with the state register.
    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c         = '0;
        c.mem_cmd = MNONE;
        case (s)
            S_RST:  begin c.reset_pc = 1'b1; c.load_pc = 1'b1; end
            S_IF1:  begin c.addr_sel = 1'b1; c.mem_cmd = MREAD; end
            S_IF2:  begin c.addr_sel = 1'b1; c.mem_cmd = MREAD; c.load_ir = 1'b1; end
            S_UPC:  begin c.load_pc = 1'b1; c.pc_sel = 2'b00; end
            S_MOVI: begin c.write = 1'b1; c.nsel = 3'b100; c.vsel = 2'b10; end
            S_GA:   begin c.nsel = 3'b100; c.loada = 1'b1; end
            S_GB:   begin c.nsel = 3'b001; c.loadb = 1'b1; end
            S_EX:   begin c.asel = 1'b1; c.loadc = 1'b1; end
            S_EXA:  begin c.loadc = 1'b1; end
            S_CMP:  begin c.loadc = 1'b1; c.loads = 1'b1; end
            S_WR:   begin c.nsel = 3'b010; c.vsel = 2'b00; c.write = 1'b1; end
            S_ADR:  begin c.bsel = 1'b1; c.loadc = 1'b1; end
            S_LA:   begin c.load_addr = 1'b1; end
            S_MR:   begin c.addr_sel = 1'b0; c.mem_cmd = MREAD; end
            // Read command is held so the synchronous memory keeps driving mdata.
            S_WM:   begin c.nsel = 3'b010; c.vsel = 2'b11; c.write = 1'b1; c.mem_cmd = MREAD; end
            S_GD:   begin c.nsel = 3'b010; c.loadb = 1'b1; end
            S_MB:   begin c.asel = 1'b1; c.loadc = 1'b1; end
            S_MW:   begin c.addr_sel = 1'b0; c.mem_cmd = MWRITE; end
            S_BGD:  begin c.nsel = 3'b010; c.loadb = 1'b1; end
            S_BMB:  begin c.asel = 1'b1; c.loadc = 1'b1; end
            S_BP:   begin c.load_pc = 1'b1; c.pc_sel = 2'b10; end
            S_HLT:  begin c.halted = 1'b1; end
            default: ;
        endcase
        return c;
    endfunction

    // opcode/op come from the IR, which is stable from UPC until the next
    // fetch, so mid-instruction branching on them is safe.
    always_comb begin
        nxt = state;
        case (state)
            S_RST:  nxt = S_IF1;
            S_IF1:  nxt = S_IF2;
            S_IF2:  nxt = S_UPC;
            S_UPC:  nxt = S_DEC;
            S_DEC: begin
                casez ({opcode, op})
                    5'b110_10: nxt = S_MOVI;
                    5'b110_00: nxt = S_GB;
                    5'b101_??: nxt = S_GA;
                    5'b011_00: nxt = S_GA;
                    5'b100_00: nxt = S_GA;
                    5'b001_00: nxt = S_BR;
                    5'b010_00: nxt = S_BGD;
                    5'b111_??: nxt = S_HLT;
                    default:   nxt = S_IF1;
                endcase
            end
            S_MOVI: nxt = S_IF1;
            S_GA:   nxt = (opcode == 3'b101) ? S_GB : S_ADR;
            S_GB: begin
                if (opcode != 3'b101)   nxt = S_EX;
                else if (op == 2'b01)   nxt = S_CMP;
                else                    nxt = S_EXA;
            end
            S_EX:   nxt = S_WR;
            S_EXA:  nxt = S_WR;
            S_CMP:  nxt = S_IF1;
            S_WR:   nxt = S_IF1;
            S_ADR:  nxt = S_LA;
            S_LA:   nxt = (opcode == 3'b011) ? S_MR : S_GD;
            S_MR:   nxt = S_WM;
            S_WM:   nxt = S_IF1;
            S_GD:   nxt = S_MB;
            S_MB:   nxt = S_MW;
            S_MW:   nxt = S_IF1;
            S_BR:   nxt = S_IF1;
            S_BGD:  nxt = S_BMB;
            S_BMB:  nxt = S_BP;
            S_BP:   nxt = S_IF1;
            S_HLT:  nxt = S_HLT;
            default: nxt = S_RST;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_RST;
            ctrl  <= decode(S_RST);
        end else begin
            state <= nxt;
            ctrl  <= decode(nxt);
        end
    end

    always_comb begin
        case (cond)
            3'b000:  taken = 1'b1;
            3'b001:  taken = Z;
            3'b010:  taken = !Z;
            3'b011:  taken = N ^ V;
            3'b100:  taken = (N ^ V) | Z;
            default: taken = 1'b0;
        endcase
    end

    // The branch PC load is the one input-dependent output: flags are read in
    // BR itself so a CMP committed at the end of its execute state is seen.
    logic br_take;
    assign br_take = (state == S_BR) && taken;

    assign nsel      = ctrl.nsel;
    assign loada     = ctrl.loada;
    assign loadb     = ctrl.loadb;
    assign loadc     = ctrl.loadc;
    assign loads     = ctrl.loads;
    assign asel      = ctrl.asel;
    assign bsel      = ctrl.bsel;
    assign vsel      = ctrl.vsel;
    assign write     = ctrl.write;
    assign load_ir   = ctrl.load_ir;
    assign load_pc   = ctrl.load_pc | br_take;
    assign reset_pc  = ctrl.reset_pc;
    assign pc_sel    = br_take ? 2'b01 : ctrl.pc_sel;
    assign addr_sel  = ctrl.addr_sel;
    assign load_addr = ctrl.load_addr;
    assign mem_cmd   = ctrl.mem_cmd;
    assign halted    = ctrl.halted;

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] opcode = '0;
    logic [1:0] op = '0;
    logic [2:0] cond = '0;
    logic       Z = 1'b0, N = 1'b0, V = 1'b0;
    logic [2:0] nsel;
    logic       loada, loadb, loadc, loads, asel, bsel;
    logic [1:0] vsel;
    logic       write, load_ir, load_pc, reset_pc;
    logic [1:0] pc_sel;
    logic       addr_sel, load_addr;
    logic [1:0] mem_cmd;
    logic       halted;

    cpu_sequencer dut (
        .clk(clk), .reset_n(reset_n),
        .opcode(opcode), .op(op), .cond(cond), .Z(Z), .N(N), .V(V),
        .nsel(nsel), .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .vsel(vsel), .write(write), .load_ir(load_ir),
        .load_pc(load_pc), .reset_pc(reset_pc), .pc_sel(pc_sel),
        .addr_sel(addr_sel), .load_addr(load_addr), .mem_cmd(mem_cmd), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] nsel;
        logic       loada, loadb, loadc, loads, asel, bsel;
        logic [1:0] vsel;
        logic       write, load_ir, load_pc, reset_pc;
        logic [1:0] pc_sel;
        logic       addr_sel, load_addr;
        logic [1:0] mem_cmd;
        logic       halted;
    } vec_t;

    vec_t obs;
    assign obs = {nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write, load_ir,
                  load_pc, reset_pc, pc_sel, addr_sel, load_addr, mem_cmd, halted};

    int   checks = 0;
    int   failures = 0;
    vec_t exp_q[$];
    vec_t rst_v, hlt_v;

    // Pending instruction fields, presented once IF1 has been observed.
    logic [2:0] p_opc, p_cond;
    logic [1:0] p_op;
    logic       p_z, p_n, p_v;

    task automatic drive();
        opcode = p_opc; op = p_op; cond = p_cond; Z = p_z; N = p_n; V = p_v;
    endtask

    // Expected per-cycle strobe list for one instruction, fetch included.
    task automatic model(input logic [2:0] c_opc, input logic [1:0] c_op,
                         input logic [2:0] c_cond, input logic c_z, c_n, c_v);
        vec_t e;
        logic tk;
        p_opc = c_opc; p_op = c_op; p_cond = c_cond; p_z = c_z; p_n = c_n; p_v = c_v;
        exp_q.delete();
        e = '0; e.addr_sel = 1; e.mem_cmd = 2'b01; exp_q.push_back(e);   // IF1
        e.load_ir = 1; exp_q.push_back(e);                                // IF2
        e = '0; e.load_pc = 1; exp_q.push_back(e);                        // UPC
        e = '0; exp_q.push_back(e);                                       // DEC
        if (c_opc == 3'b110 && c_op == 2'b10) begin
            e = '0; e.write = 1; e.nsel = 3'b100; e.vsel = 2'b10; exp_q.push_back(e);
        end else if (c_opc == 3'b110 && c_op == 2'b00) begin
            e = '0; e.nsel = 3'b001; e.loadb = 1; exp_q.push_back(e);
            e = '0; e.asel = 1; e.loadc = 1; exp_q.push_back(e);
            e = '0; e.nsel = 3'b010; e.write = 1; exp_q.push_back(e);
        end else if (c_opc == 3'b101) begin
            e = '0; e.nsel = 3'b100; e.loada = 1; exp_q.push_back(e);
            e = '0; e.nsel = 3'b001; e.loadb = 1; exp_q.push_back(e);
            e = '0; e.loadc = 1; e.loads = (c_op == 2'b01); exp_q.push_back(e);
            if (c_op != 2'b01) begin
                e = '0; e.nsel = 3'b010; e.write = 1; exp_q.push_back(e);
            end
        end else if ((c_opc == 3'b011 || c_opc == 3'b100) && c_op == 2'b00) begin
            e = '0; e.nsel = 3'b100; e.loada = 1; exp_q.push_back(e);
            e = '0; e.bsel = 1; e.loadc = 1; exp_q.push_back(e);
            e = '0; e.load_addr = 1; exp_q.push_back(e);
            if (c_opc == 3'b011) begin
                e = '0; e.mem_cmd = 2'b01; exp_q.push_back(e);
                e = '0; e.nsel = 3'b010; e.vsel = 2'b11; e.write = 1; e.mem_cmd = 2'b01;
                exp_q.push_back(e);
            end else begin
                e = '0; e.nsel = 3'b010; e.loadb = 1; exp_q.push_back(e);
                e = '0; e.asel = 1; e.loadc = 1; exp_q.push_back(e);
                e = '0; e.mem_cmd = 2'b10; exp_q.push_back(e);
            end
        end else if (c_opc == 3'b001 && c_op == 2'b00) begin
            case (c_cond)
                3'd0: tk = 1'b1;
                3'd1: tk = c_z;
                3'd2: tk = !c_z;
                3'd3: tk = (c_n != c_v);
                3'd4: tk = (c_n != c_v) || c_z;
                default: tk = 1'b0;
            endcase
            e = '0;
            if (tk) begin e.load_pc = 1; e.pc_sel = 2'b01; end
            exp_q.push_back(e);
        end else if (c_opc == 3'b010 && c_op == 2'b00) begin
            e = '0; e.nsel = 3'b010; e.loadb = 1; exp_q.push_back(e);
            e = '0; e.asel = 1; e.loadc = 1; exp_q.push_back(e);
            e = '0; e.load_pc = 1; e.pc_sel = 2'b10; exp_q.push_back(e);
        end else if (c_opc == 3'b111) begin
            exp_q.push_back(hlt_v);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== rst_v) begin
            failures++; $display("FAIL reset_held got=%h exp=%h", obs, rst_v);
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if (obs !== rst_v) begin
            failures++; $display("FAIL reset_release got=%h exp=%h", obs, rst_v);
        end
        model(3'b000, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0);   // undefined opcode: NOP
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_q[i]) begin
                failures++; $display("FAIL reset_nop step=%0d got=%h exp=%h", i, obs, exp_q[i]);
            end
            if (i == 0) drive();
        end
    endtask

    task automatic test_mov();
        logic [1:0] ops [3] = '{2'b10, 2'b00, 2'b10};
        for (int k = 0; k < 3; k++) begin
            model(3'b110, ops[k], 3'($urandom_range(0, 7)), 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < exp_q.size(); i++) begin
                @(negedge clk);
                checks++;
                if (obs !== exp_q[i]) begin
                    failures++; $display("FAIL mov k=%0d step=%0d got=%h exp=%h", k, i, obs, exp_q[i]);
                end
                if (i == 0) drive();
            end
        end
    endtask

    task automatic test_alu();
        logic [1:0] ops [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        for (int k = 0; k < 4; k++) begin
            model(3'b101, ops[k], 3'b000, 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < exp_q.size(); i++) begin
                @(negedge clk);
                checks++;
                if (obs !== exp_q[i]) begin
                    failures++; $display("FAIL alu op=%0d step=%0d got=%h exp=%h", ops[k], i, obs, exp_q[i]);
                end
                if (i == 0) drive();
            end
        end
    endtask

    task automatic test_ldr_str();
        logic [2:0] opcs [3] = '{3'b011, 3'b100, 3'b011};
        for (int k = 0; k < 3; k++) begin
            model(opcs[k], 2'b00, 3'b000, 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < exp_q.size(); i++) begin
                @(negedge clk);
                checks++;
                if (obs !== exp_q[i]) begin
                    failures++; $display("FAIL ldr_str opc=%0d step=%0d got=%h exp=%h", opcs[k], i, obs, exp_q[i]);
                end
                if (i == 0) drive();
            end
        end
    endtask

    task automatic test_branch();
        // {cond, Z, N, V}
        logic [5:0] tbl [10] = '{6'b001_100, 6'b001_000, 6'b011_010, 6'b111_111,
                                 6'b000_000, 6'b010_000, 6'b010_100, 6'b100_100,
                                 6'b100_011, 6'b011_011};
        for (int k = 0; k < 10; k++) begin
            model(3'b001, 2'b00, tbl[k][5:3], tbl[k][2], tbl[k][1], tbl[k][0]);
            for (int i = 0; i < exp_q.size(); i++) begin
                @(negedge clk);
                checks++;
                if (obs !== exp_q[i]) begin
                    failures++; $display("FAIL branch k=%0d step=%0d got=%h exp=%h", k, i, obs, exp_q[i]);
                end
                if (i == 0) drive();
            end
        end
        model(3'b010, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0);   // BX
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_q[i]) begin
                failures++; $display("FAIL bx step=%0d got=%h exp=%h", i, obs, exp_q[i]);
            end
            if (i == 0) drive();
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 60; k++) begin
            model(3'($urandom_range(0, 6)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            for (int i = 0; i < exp_q.size(); i++) begin
                @(negedge clk);
                checks++;
                if (obs !== exp_q[i]) begin
                    failures++;
                    $display("FAIL random k=%0d opc=%0d op=%0d step=%0d got=%h exp=%h",
                             k, p_opc, p_op, i, obs, exp_q[i]);
                end
                if (i == 0) drive();
            end
        end
    endtask

    task automatic test_halt();
        model(3'b111, 2'($urandom_range(0, 3)), 3'b000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_q[i]) begin
                failures++; $display("FAIL halt_entry step=%0d got=%h exp=%h", i, obs, exp_q[i]);
            end
            if (i == 0) drive();
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== hlt_v) begin
                failures++; $display("FAIL halt_hold cycle=%0d got=%h exp=%h", c, obs, hlt_v);
            end
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (obs !== rst_v) begin
            failures++; $display("FAIL halt_reset got=%h exp=%h", obs, rst_v);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset_mid();
        model(3'b100, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0);   // STR, cut off in MW
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_q[i]) begin
                failures++; $display("FAIL mid_str step=%0d got=%h exp=%h", i, obs, exp_q[i]);
            end
            if (i == 0) drive();
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (mem_cmd !== 2'b00 || obs !== rst_v) begin
            failures++; $display("FAIL mid_reset got=%h exp=%h", obs, rst_v);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model(3'b110, 2'b10, 3'b000, 1'b0, 1'b0, 1'b0);   // recovers with a fresh fetch
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_q[i]) begin
                failures++; $display("FAIL mid_recover step=%0d got=%h exp=%h", i, obs, exp_q[i]);
            end
            if (i == 0) drive();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_v = '0; rst_v.reset_pc = 1'b1; rst_v.load_pc = 1'b1;
        hlt_v = '0; hlt_v.halted = 1'b1;
        test_reset();
        test_mov();
        test_alu();
        test_ldr_str();
        test_branch();
        test_random();
        test_halt();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Moore control FSM for the Simple RISC Machine. It fetches each instruction, advances the PC, decodes, and sequences the shared register-file/ALU datapath and data memory.
- It takes opcode/op from the instruction decoder, plus cond and status flags Z/N/V.
- It drives the decoder's one-hot nsel and every datapath, PC, IR and memory strobe.
- Supported instructions: MOV, ALU ops, LDR/STR, conditional branch, BX and HALT.

Parameters:
- MNONE, 2'b00, mem_cmd encoding for idle.
- MREAD, 2'b01, mem_cmd encoding for read.
- MWRITE, 2'b10, mem_cmd encoding for write.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- opcode  in  3  instruction bits 15:13 from the decoder
- op  in  2  instruction bits 12:11 from the decoder
- cond  in  3  instruction bits 10:8 (branch condition)
- Z, N, V  in  1 each  status register flags
- nsel  out  3  one-hot register select: 100=Rn, 010=Rd, 001=Rm
- loada, loadb, loadc, loads  out  1 each  datapath register enables
- asel  out  1  1 = ALU A input is 0
- bsel  out  1  1 = ALU B input is sximm5
- vsel  out  2  writeback source: 00=C, 01=PC, 10=sximm8, 11=mdata
- write  out  1  register-file write enable
- load_ir  out  1  instruction register enable
- load_pc, reset_pc  out  1 each  PC enable; reset_pc forces next PC to 0
- pc_sel  out  2  next PC: 00=PC+1, 01=PC+sximm8, 10=datapath C
- addr_sel  out  1  1 = memory address is PC, 0 = address register
- load_addr  out  1  address register enable
- mem_cmd  out  2  memory command
- halted  out  1  high in the HALT state

Behaviour:
- Single state register. Outputs are a pure function of state (Moore).
- Any strobe not listed for a state is 0. nsel and vsel default to 000 and 00; mem_cmd defaults to MNONE.
- reset_n low → state RST immediately (asynchronous), overriding any mid-instruction state. Memory and register writes in progress are abandoned.
- RST: reset_pc=1, load_pc=1, all else 0. Next state: IF1.
- Fetch (memory is synchronous, read latency 1):
  - IF1: addr_sel=1, mem_cmd=MREAD.
  - IF2: addr_sel=1, mem_cmd=MREAD, load_ir=1.
  - UPC: load_pc=1, pc_sel=00.
  - DEC: no strobes; dispatch on {opcode,op}.
- Dispatch from DEC:
  - 110_10 MOVI: write=1, nsel=100, vsel=10 → IF1.
  - 110_00 MOV: GB (nsel=001, loadb) → EX (asel=1, loadc) → WR (nsel=010, vsel=00, write) → IF1.
  - 101_xx ALU: GA (nsel=100, loada) → GB → EXA (loadc; loads only when op=01 CMP) → if op=01 go to IF1, else WR → IF1.
  - 011_00 LDR: GA → ADR (bsel=1, loadc) → LA (load_addr) → MR (addr_sel=0, mem_cmd=MREAD) → WM (nsel=010, vsel=11, write, mem_cmd=MREAD held) → IF1.
  - 100_00 STR: GA → ADR → LA → GD (nsel=010, loadb) → MB (asel=1, loadc) → MW (addr_sel=0, mem_cmd=MWRITE) → IF1.
  - 001_00 Bcond: BR. In BR, load_pc=1 and pc_sel=01 only if the condition holds → IF1.
    - Conditions: cond 000 always; 001 Z; 010 !Z; 011 N≠V; 100 (N≠V)|Z; 101–111 never taken.
    - BR is the only state whose outputs also depend on inputs (cond, flags).
  - 010_00 BX: BGD (nsel=010, loadb) → BMB (asel=1, loadc) → BP (load_pc, pc_sel=10) → IF1.
  - 111_xx HALT: HLT. halted=1, no strobes; stays in HLT until reset_n is asserted.
  - Any other {opcode,op}: treated as NOP → IF1.
- Exactly one nsel bit is high whenever any read or write is strobed. nsel is never non-one-hot.
- write and load_pc are never asserted in the same cycle.
- Cycle counts, fetch through last state inclusive:
  - MOVI 5; MOV 7; ADD 8; CMP 7; LDR 9; STR 10
  - B taken or not taken 5; BX 7
- Flags are sampled only in BR. A CMP immediately preceding a branch is visible, because loads commits at the end of EXA.

Test Plan:
- Reset: reset_n low for 2 cycles, release → one RST cycle (reset_pc=1, load_pc=1), then IF1 with addr_sel=1, mem_cmd=01; IF2 has load_ir=1.
- MOVI (opcode 110, op 10) → after DEC, a single cycle with write=1, nsel=100, vsel=10, then IF1. Total 5 cycles per instruction.
- ADD then CMP: ADD → GA nsel=100 loada, GB nsel=001 loadb, EXA loadc=1 loads=0, WR nsel=010 write. CMP → loads=1 and no WR state.
- LDR/STR: LDR shows bsel=1 in ADR, load_addr in LA, mem_cmd=01 with addr_sel=0 in MR/WM, vsel=11 write in WM. STR shows GD nsel=010 loadb, MB asel=1, MW mem_cmd=10.
- Branch: cond=001 with Z=1 → BR load_pc=1, pc_sel=01. Z=0 → BR all strobes 0. cond=011 with N=1, V=0 → taken. cond=111 → never taken.
- HALT and mid-instruction reset: opcode 111 → halted=1 held for 20 cycles. Drop reset_n while in MW → same cycle mem_cmd=00, state RST.
